// File: rtl/umi_req_arbiter.sv
// umi_req_arbiter
//   N-to-1 UMI request arbiter. Round-robin grant among requesters, held
//   for a whole multi-beat transaction and released on the EOM beat
//   (cmd[22]). Datapath is purely combinational; only the arbitration
//   state (state, rr_ptr, lock_id) is registered.
//
// Ports
//   clk, nreset       clock, asynchronous active-low reset
//   arb_mask[N]       1 = requester excluded from new grants
//   umi_in_*          packed per-requester request channel (i at [i*W +: W])
//   umi_in_ready[N]   only the granted bit can be 1
//   umi_out_*         muxed request channel to the shared downstream port
//   arb_grant[N]      one-hot current grant (0 when none)
//   arb_locked        1 while a multi-beat transaction holds the grant
//
// Optional feature
//   UMI_ARB_QOS_EN    in IDLE only requesters with maximal cmd[19:16]
//                     compete; round-robin breaks ties.
module umi_req_arbiter #(
  parameter int N  = 4,
  parameter int DW = 128,
  parameter int AW = 64,
  parameter int CW = 32
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    arb_mask,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic [N-1:0]    arb_grant,
  output logic            arb_locked
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] lock_id_q, lock_id_d;

  logic [N-1:0]  eligible;
  logic [N-1:0]  cand;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic          xfer;
  logic [IW-1:0] gnt_next;

  // Arbitration: pick the first candidate at/after rr_ptr, or the lock holder.
  always_comb begin
    eligible = umi_in_valid & ~arb_mask;
    cand     = eligible;
`ifdef UMI_ARB_QOS_EN
    begin
      logic [3:0] max_qos;
      max_qos = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (eligible[i] && (umi_in_cmd[i*CW+16 +: 4] > max_qos))
          max_qos = umi_in_cmd[i*CW+16 +: 4];
      end
      for (int unsigned i = 0; i < N; i++)
        cand[i] = eligible[i] && (umi_in_cmd[i*CW+16 +: 4] == max_qos);
    end
`endif
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr_q) + k) % N;
      if (!gnt_any && cand[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    if (state_q == ST_LOCKED) begin
      gnt_any = 1'b1;
      gnt_idx = lock_id_q;
    end
    // Inputs may already be valid during reset; the grant must stay quiet.
    if (!nreset) begin
      gnt_any = 1'b0;
    end
  end

  // Datapath mux; outputs are zero whenever nothing is granted.
  always_comb begin
    arb_grant       = '0;
    umi_out_valid   = 1'b0;
    umi_out_cmd     = '0;
    umi_out_dstaddr = '0;
    umi_out_srcaddr = '0;
    umi_out_data    = '0;
    if (gnt_any) begin
      arb_grant[gnt_idx] = 1'b1;
      umi_out_valid      = umi_in_valid[gnt_idx];
      umi_out_cmd        = umi_in_cmd[gnt_idx*CW +: CW];
      umi_out_dstaddr    = umi_in_dstaddr[gnt_idx*AW +: AW];
      umi_out_srcaddr    = umi_in_srcaddr[gnt_idx*AW +: AW];
      umi_out_data       = umi_in_data[gnt_idx*DW +: DW];
    end
    umi_in_ready = arb_grant & {N{umi_out_ready}};
    arb_locked   = nreset && (state_q == ST_LOCKED);
  end

  always_comb begin
    xfer     = umi_out_valid & umi_out_ready;
    gnt_next = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      if (umi_out_cmd[22]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = gnt_next;
      end else begin
        state_d   = ST_LOCKED;
        lock_id_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule
